// File: rtl/y86_mem_pkg.sv
// Shared types for the Y86-64 data-memory path: FSM states, word size, stat codes.
// Saturating counter helper used by the optional statistics block.
package y86_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam int MEM_WORD_BYTES = 8;

  // Y86-64 processor status codes; a responder error corresponds to ADR.
  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } y86_stat_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/y86_data_mem_responder_if.sv
// Request/response bundle between the core's memory stage (master) and the responder (slave).
// Both directions use valid/ready; one request may be outstanding.
interface y86_data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/y86_mem_array.sv
// Byte-addressed storage with one 8-byte little-endian port: combinational read, write on clk.
// No backpressure; contents are never reset.
module y86_mem_array
  import y86_mem_pkg::*;
#(
  parameter  int MEM_BYTES = 8192,
  localparam int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [63:0]       wdata_i,
  output logic [63:0]       rdata_o
);

  logic [7:0] mem_q [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < MEM_WORD_BYTES; i++) begin
        mem_q[addr_i + ADDR_W'(i)] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < MEM_WORD_BYTES; i++) begin
      rdata_o[8*i +: 8] = mem_q[addr_i + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/y86_data_mem_responder.sv
// Y86-64 data-memory responder: one 8-byte access at a time, response LATENCY cycles after accept,
// req_ready low until the response is taken. Y86_DMEM_STATS_EN adds saturating access counters.
module y86_data_mem_responder
  import y86_mem_pkg::*;
#(
  parameter int MEM_BYTES = 8192,
  parameter int LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  y86_data_mem_responder_if.slave  mem
`ifdef Y86_DMEM_STATS_EN
  ,
  output logic [31:0]              stat_reads,
  output logic [31:0]              stat_writes,
  output logic [31:0]              stat_errors
`endif
);

  localparam int ADDR_W = $clog2(MEM_BYTES);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_e  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [63:0] rsp_rdata_q;
  logic        rsp_error_q;

  logic        accept;
  logic        addr_err;
  logic        arr_we;
  logic [63:0] arr_rdata;

  // Full 64-bit compare so addresses near 2^64 cannot alias into the array.
  assign addr_err = mem.req_addr > 64'(MEM_BYTES - MEM_WORD_BYTES);
  assign accept   = mem.req_valid && req_ready_q;
  assign arr_we   = accept && mem.req_write && !addr_err && !rst;
  assign cnt_d    = cnt_q - CNT_W'(1);

  y86_mem_array #(
    .MEM_BYTES (MEM_BYTES)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (mem.req_addr[ADDR_W-1:0]),
    .wdata_i (mem.req_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            rsp_error_q <= addr_err;
            rsp_rdata_q <= (!addr_err && !mem.req_write) ? arr_rdata : '0;
            if (LATENCY == 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (mem.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem.req_ready = req_ready_q;
  assign mem.rsp_valid = rsp_valid_q;
  assign mem.rsp_rdata = rsp_rdata_q;
  assign mem.rsp_error = rsp_error_q;

`ifdef Y86_DMEM_STATS_EN
  logic [31:0] reads_q, writes_q, errors_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      reads_q  <= '0;
      writes_q <= '0;
      errors_q <= '0;
    end else if (accept) begin
      if (addr_err)           errors_q <= sat_inc32(errors_q);
      else if (mem.req_write) writes_q <= sat_inc32(writes_q);
      else                    reads_q  <= sat_inc32(reads_q);
    end
  end

  assign stat_reads  = reads_q;
  assign stat_writes = writes_q;
  assign stat_errors = errors_q;
`endif

endmodule
